calc_sweep_driver: RTL



---
 rtl/calc_sweep_driver.sv | 201 ++++++++++++++++++++
 1 files changed

// File: rtl/calc_sweep_driver.sv
// calc_sweep_driver: on-chip initiator that sweeps every (val1, val2, opcode)
// vector through a 32-bit combinational calculator. It holds each vector for
// WAIT_CYCLES clocks, samples the result, and accumulates a checksum and a
// sample count.
// Optional build macro CALC_SWEEP_CHECK_EN adds an internal golden model,
// miscompare counting, first-failure capture and a pass flag.
module calc_sweep_driver #(
  parameter int unsigned VAL_COUNT   = 255,
  parameter int unsigned WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic [31:0] val1,
  output logic [31:0] val2,
  output logic [1:0]  operation,
  input  logic [31:0] result,
  output logic [31:0] checksum,
  output logic [31:0] op_count
`ifdef CALC_SWEEP_CHECK_EN
  ,
  output logic [31:0] mismatch_count,
  output logic [31:0] first_bad_val1,
  output logic [31:0] first_bad_val2,
  output logic [1:0]  first_bad_op,
  output logic        pass
`endif
);

  localparam int unsigned DW = 32;
  localparam int unsigned OW = 2;
  localparam logic [DW-1:0] VAL_LAST    = DW'(VAL_COUNT);
  localparam logic [DW-1:0] WAIT_RELOAD = DW'(WAIT_CYCLES - 1);
  localparam logic [OW-1:0] OP_LAST     = OW'(3);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    FINISH = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] wait_q, wait_d;
  logic          busy_d, done_d;
  logic [DW-1:0] val1_d, val2_d, checksum_d, op_count_d;
  logic [OW-1:0] operation_d;
  logic          load_c;
  logic          sample_c;
  logic          last_vec_c;

  assign last_vec_c = (val1 == VAL_LAST) && (val2 == VAL_LAST) && (operation == OP_LAST);

  // Next-state and next-output logic for the sweep sequencer.
  always_comb begin
    state_d     = state_q;
    wait_d      = wait_q;
    busy_d      = busy;
    done_d      = done;
    val1_d      = val1;
    val2_d      = val2;
    operation_d = operation;
    checksum_d  = checksum;
    op_count_d  = op_count;
    load_c      = 1'b0;
    sample_c    = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          load_c      = 1'b1;
          val1_d      = DW'(1);
          val2_d      = DW'(1);
          operation_d = '0;
          checksum_d  = '0;
          op_count_d  = '0;
          done_d      = 1'b0;
          busy_d      = 1'b1;
          wait_d      = WAIT_RELOAD;
          state_d     = APPLY;
        end
      end
      APPLY: begin
        if (wait_q != '0) begin
          wait_d = wait_q - DW'(1);
        end else begin
          sample_c   = 1'b1;
          checksum_d = checksum + result;
          op_count_d = op_count + DW'(1);
          wait_d     = WAIT_RELOAD;
          if (last_vec_c) begin
            // Final vector stays on the bus; sweep completes.
            busy_d  = 1'b0;
            done_d  = 1'b1;
            state_d = FINISH;
          end else if (operation != OP_LAST) begin
            operation_d = operation + OW'(1);
          end else begin
            operation_d = '0;
            if (val1 == VAL_LAST) begin
              val1_d = DW'(1);
              val2_d = val2 + DW'(1);
            end else begin
              val1_d = val1 + DW'(1);
            end
          end
        end
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Sequencer state and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      wait_q    <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      val1      <= '0;
      val2      <= '0;
      operation <= '0;
      checksum  <= '0;
      op_count  <= '0;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      busy      <= busy_d;
      done      <= done_d;
      val1      <= val1_d;
      val2      <= val2_d;
      operation <= operation_d;
      checksum  <= checksum_d;
      op_count  <= op_count_d;
    end
  end

`ifdef CALC_SWEEP_CHECK_EN
  logic [DW-1:0] expected_c;
  logic [DW-1:0] mismatch_count_d, first_bad_val1_d, first_bad_val2_d;
  logic [OW-1:0] first_bad_op_d;
  logic          pass_d;

  // Golden calculator for the vector currently on the bus.
  always_comb begin
    expected_c = '0;
    case (operation)
      2'd0:    expected_c = val1 + val2;
      2'd1:    expected_c = val1 - val2;
      2'd2:    expected_c = val1 & val2;
      default: expected_c = val1 | val2;
    endcase
  end

  // Miscompare counting and first-failure capture.
  always_comb begin
    mismatch_count_d = mismatch_count;
    first_bad_val1_d = first_bad_val1;
    first_bad_val2_d = first_bad_val2;
    first_bad_op_d   = first_bad_op;
    if (load_c) begin
      mismatch_count_d = '0;
      first_bad_val1_d = '0;
      first_bad_val2_d = '0;
      first_bad_op_d   = '0;
    end else if (sample_c && (result != expected_c)) begin
      if (mismatch_count == '0) begin
        first_bad_val1_d = val1;
        first_bad_val2_d = val2;
        first_bad_op_d   = operation;
      end
      mismatch_count_d = mismatch_count + DW'(1);
    end
    pass_d = done_d && (mismatch_count_d == '0);
  end

  // Checker registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mismatch_count <= '0;
      first_bad_val1 <= '0;
      first_bad_val2 <= '0;
      first_bad_op   <= '0;
      pass           <= 1'b0;
    end else begin
      mismatch_count <= mismatch_count_d;
      first_bad_val1 <= first_bad_val1_d;
      first_bad_val2 <= first_bad_val2_d;
      first_bad_op   <= first_bad_op_d;
      pass           <= pass_d;
    end
  end
`endif

endmodule
